ip_srom_sequencer: RTL

//  Command sequencer above ip_srom's byte channel (n_cs/rd/wr/busy/wdata/rdata/rdata_en).

---
 rtl/ip_srom_sequencer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ip_srom_sequencer.sv
// Command sequencer above the ip_srom byte channel: turns one host request into the
// serial-flash byte sequence (WREN, opcode, address, data phase, WIP polling).
module ip_srom_sequencer #(
    parameter int unsigned CS_GAP     = 4,
    parameter int unsigned POLL_LIMIT = 1000000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        initial_busy,
    input  logic        req,
    input  logic [1:0]  req_cmd,
    input  logic [23:0] req_address,
    input  logic [7:0]  req_length,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic        dat_rd,
    input  logic [7:0]  dat_in,
    output logic [7:0]  dat_out,
    output logic        dat_valid,
    output logic        srom_n_cs,
    output logic        srom_rd,
    output logic        srom_wr,
    output logic [7:0]  srom_wdata,
    input  logic        srom_busy,
    input  logic [7:0]  srom_rdata,
    input  logic        srom_rdata_en
);

    localparam int unsigned GW = (CS_GAP < 2) ? 1 : $clog2(CS_GAP + 1);
    localparam int unsigned PW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT);

    typedef enum logic [3:0] {
        S_IDLE, S_WREN, S_GAP, S_OPC, S_ADDR, S_WDATA, S_RDATA, S_POLL_OPC, S_POLL_RD, S_FIN
    } state_t;

    typedef enum logic [2:0] {P_ISSUE, P_STRB, P_WAIT, P_FETCH, P_FLUSH} phase_t;

    typedef enum logic [1:0] {CMD_READ = 2'd0, CMD_PROG = 2'd1, CMD_ERASE = 2'd2, CMD_RDID = 2'd3} cmd_t;

    state_t        state_q, next_q;
    phase_t        ph_q;
    cmd_t          cmd_q;
    logic [23:0]   addr_q;
    logic [8:0]    cnt_q;
    logic [1:0]    abyte_q;
    logic [GW-1:0] gap_q;
    logic [PW-1:0] poll_q;
    logic          n_cs_q, rd_q, wr_q, done_q, err_q, dat_rd_q, dat_valid_q;
    logic [7:0]    wdata_q, dat_out_q;

    logic [7:0]    tx_byte;
    logic          is_rd;
    logic [8:0]    len9;
    logic          overrun;
    logic          gap_ok;

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            S_WREN:     tx_byte = 8'h06;
            S_OPC: begin
                case (cmd_q)
                    CMD_READ:  tx_byte = 8'h03;
                    CMD_PROG:  tx_byte = 8'h02;
                    CMD_ERASE: tx_byte = 8'h20;
                    default:   tx_byte = 8'h9F;
                endcase
            end
            S_ADDR: begin
                case (abyte_q)
                    2'd0:    tx_byte = addr_q[23:16];
                    2'd1:    tx_byte = addr_q[15:8];
                    default: tx_byte = addr_q[7:0];
                endcase
            end
            S_WDATA:    tx_byte = dat_in;
            S_POLL_OPC: tx_byte = 8'h05;
            default:    tx_byte = 8'h00;
        endcase
        is_rd   = (state_q == S_RDATA) || (state_q == S_POLL_RD);
        len9    = (req_length == 8'd0) ? 9'd256 : {1'b0, req_length};
        overrun = ({2'b00, req_address[7:0]} + {1'b0, len9}) > 10'd256;
        gap_ok  = (gap_q <= GW'(1));
    end

    assign ready = (state_q == S_IDLE) && !initial_busy;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            next_q      <= S_IDLE;
            ph_q        <= P_ISSUE;
            cmd_q       <= CMD_READ;
            addr_q      <= '0;
            cnt_q       <= '0;
            abyte_q     <= '0;
            gap_q       <= GW'(CS_GAP);
            poll_q      <= '0;
            n_cs_q      <= 1'b1;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dat_rd_q    <= 1'b0;
            dat_out_q   <= '0;
            dat_valid_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dat_rd_q    <= 1'b0;
            dat_valid_q <= 1'b0;
            // gap counter reloads while the chip select is low and drains while it is high
            if (!n_cs_q)
                gap_q <= GW'(CS_GAP);
            else if (gap_q != '0)
                gap_q <= gap_q - GW'(1);

            case (state_q)
                S_IDLE: begin
                    wdata_q <= '0;
                    if (req && ready) begin
                        cmd_q  <= cmd_t'(req_cmd);
                        addr_q <= req_address;
                        cnt_q  <= len9;
                        if (cmd_t'(req_cmd) == CMD_PROG && overrun) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                            next_q  <= (cmd_t'(req_cmd) == CMD_PROG || cmd_t'(req_cmd) == CMD_ERASE)
                                       ? S_WREN : S_OPC;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_ok) begin
                        n_cs_q  <= 1'b0;
                        state_q <= next_q;
                        ph_q    <= P_ISSUE;
                        abyte_q <= '0;
                    end
                end
                S_WREN, S_OPC, S_ADDR, S_WDATA, S_RDATA, S_POLL_OPC, S_POLL_RD: begin
                    case (ph_q)
                        P_FETCH: ph_q <= P_ISSUE;
                        P_ISSUE: begin
                            if (is_rd) begin
                                rd_q <= 1'b1;
                            end else begin
                                wr_q    <= 1'b1;
                                wdata_q <= tx_byte;
                            end
                            ph_q <= P_STRB;
                        end
                        P_STRB: begin
                            if (!srom_busy) begin
                                rd_q <= 1'b0;
                                wr_q <= 1'b0;
                                if (is_rd) begin
                                    ph_q <= P_WAIT;
                                end else begin
                                    ph_q <= P_ISSUE;
                                    case (state_q)
                                        S_WREN: begin
                                            ph_q   <= P_FLUSH;
                                            next_q <= S_OPC;
                                        end
                                        S_OPC: begin
                                            if (cmd_q == CMD_RDID) begin
                                                state_q <= S_RDATA;
                                                cnt_q   <= 9'd3;
                                            end else begin
                                                state_q <= S_ADDR;
                                                abyte_q <= '0;
                                            end
                                        end
                                        S_ADDR: begin
                                            if (abyte_q != 2'd2) begin
                                                abyte_q <= abyte_q + 2'd1;
                                            end else if (cmd_q == CMD_READ) begin
                                                state_q <= S_RDATA;
                                            end else if (cmd_q == CMD_PROG) begin
                                                state_q  <= S_WDATA;
                                                ph_q     <= P_FETCH;
                                                dat_rd_q <= 1'b1;
                                            end else begin
                                                ph_q   <= P_FLUSH;
                                                next_q <= S_POLL_OPC;
                                            end
                                        end
                                        S_WDATA: begin
                                            if (cnt_q != 9'd1) begin
                                                cnt_q    <= cnt_q - 9'd1;
                                                ph_q     <= P_FETCH;
                                                dat_rd_q <= 1'b1;
                                            end else begin
                                                ph_q   <= P_FLUSH;
                                                next_q <= S_POLL_OPC;
                                            end
                                        end
                                        default: begin
                                            state_q <= S_POLL_RD;
                                            poll_q  <= '0;
                                        end
                                    endcase
                                end
                            end
                        end
                        P_WAIT: begin
                            if (srom_rdata_en) begin
                                ph_q <= P_ISSUE;
                                if (state_q == S_RDATA) begin
                                    dat_out_q   <= srom_rdata;
                                    dat_valid_q <= 1'b1;
                                    if (cnt_q != 9'd1) begin
                                        cnt_q <= cnt_q - 9'd1;
                                    end else begin
                                        n_cs_q  <= 1'b1;
                                        state_q <= S_FIN;
                                        done_q  <= 1'b1;
                                    end
                                end else if (!srom_rdata[0] || poll_q == PW'(POLL_LIMIT - 1)) begin
                                    n_cs_q  <= 1'b1;
                                    state_q <= S_FIN;
                                    done_q  <= 1'b1;
                                    err_q   <= srom_rdata[0];
                                end else begin
                                    poll_q <= poll_q + PW'(1);
                                end
                            end
                        end
                        default: begin
                            // last written byte is still shifting out while busy is high
                            if (!srom_busy) begin
                                n_cs_q  <= 1'b1;
                                state_q <= S_GAP;
                            end
                        end
                    endcase
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign dat_rd     = dat_rd_q;
    assign dat_out    = dat_out_q;
    assign dat_valid  = dat_valid_q;
    assign srom_n_cs  = n_cs_q;
    assign srom_rd    = rd_q;
    assign srom_wr    = wr_q;
    assign srom_wdata = wdata_q;

endmodule
